// File: rtl/vanish_pkg.sv
// rtl/vanish_pkg.sv - shared cell codes, player constants and player-to-cell mapping
package vanish_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_X     = 2'b10;

    localparam logic PL_O = 1'b0;
    localparam logic PL_X = 1'b1;

    function automatic logic [1:0] player_code(input logic player);
        return (player == PL_X) ? CELL_X : CELL_O;
    endfunction

endpackage

// File: rtl/piece_fifo.sv
// rtl/piece_fifo.sv - per-player FIFO of placed cell positions, oldest at head
//
// Ports:
//   clk, rst (sync active-low), clr (sync clear)
//   push/din  - append a position
//   pop       - drop the head; push+pop together keeps count and rotates
//   head      - oldest position held (0 when empty after reset)
//   count     - entries held, 0..DEPTH
//   full/empty
module piece_fifo #(
    parameter int DEPTH = 3,
    parameter int PW    = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] din,
    output logic [PW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vanish_board_recorder.sv
// rtl/vanish_board_recorder.sv - board-state recorder for vanishing-pieces tic-tac-toe
//
// Optional feature macro: VANISH_PREVIEW_EN (adds vanish_o/x and vanish_o/x_vld).
// Ports:
//   clk, rst (sync active-low), clr (sync new-game clear)
//   mv_valid/mv_player/mv_pos - move request
//   board   - packed grid, cell i at [2i+1:2i]
//   turn    - player expected next
//   acc/rej - one-cycle move verdict pulses
//   cnt_o/cnt_x - pieces recorded per player
//   vanish_* - FIFO head previews (VANISH_PREVIEW_EN only)
module vanish_board_recorder
    import vanish_pkg::*;
#(
    parameter int CELLS      = 9,
    parameter int DEPTH      = 3,
    parameter int VANISH_OWN = 1,
    parameter int FIRST      = 0,
    parameter int PW         = $clog2(CELLS),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               mv_valid,
    input  logic               mv_player,
    input  logic [PW-1:0]      mv_pos,
    output logic [2*CELLS-1:0] board,
    output logic               turn,
    output logic               acc,
    output logic               rej,
    output logic [CW-1:0]      cnt_o,
`ifdef VANISH_PREVIEW_EN
    output logic [CW-1:0]      cnt_x,
    output logic [PW-1:0]      vanish_o,
    output logic [PW-1:0]      vanish_x,
    output logic               vanish_o_vld,
    output logic               vanish_x_vld
`else
    output logic [CW-1:0]      cnt_x
`endif
);

    logic [1:0]    cells [CELLS];
    logic          turn_q;
    logic          acc_q;
    logic          rej_q;

    logic [PW-1:0] head_o, head_x;
    logic          full_o, full_x;
    logic          empty_o, empty_x;

    logic          in_range;
    logic [1:0]    target;
    logic          legal;
    logic          take;
    logic          mover_full, opp_full, mover_empty, opp_empty;
    logic [PW-1:0] mover_head, opp_head;
    logic          pop_mover, pop_opp;
    logic          push_o, push_x, pop_o, pop_x;
    logic          clear_en;
    logic [PW-1:0] clear_pos;

    always_comb begin
        in_range    = ({1'b0, mv_pos} < (PW + 1)'(CELLS));
        target      = in_range ? cells[mv_pos] : CELL_X;
        legal       = mv_valid && (mv_player == turn_q) && in_range && (target == CELL_EMPTY);
        take        = legal && !clr;

        mover_full  = (turn_q == PL_X) ? full_x  : full_o;
        opp_full    = (turn_q == PL_X) ? full_o  : full_x;
        mover_empty = (turn_q == PL_X) ? empty_x : empty_o;
        opp_empty   = (turn_q == PL_X) ? empty_o : empty_x;
        mover_head  = (turn_q == PL_X) ? head_x  : head_o;
        opp_head    = (turn_q == PL_X) ? head_o  : head_x;

        // A full mover always drops its oldest record so its FIFO never
        // exceeds DEPTH. In own mode that piece leaves the board too; in
        // opponent mode the record is dropped but the piece stays, and the
        // count saturates at DEPTH.
        pop_mover   = take && mover_full && !mover_empty;
        pop_opp     = (VANISH_OWN == 0) && take && mover_full && opp_full && !opp_empty;

        push_o      = take && (turn_q == PL_O);
        push_x      = take && (turn_q == PL_X);
        pop_o       = (turn_q == PL_O) ? pop_mover : pop_opp;
        pop_x       = (turn_q == PL_X) ? pop_mover : pop_opp;

        if (VANISH_OWN != 0) begin
            clear_en  = pop_mover;
            clear_pos = mover_head;
        end else begin
            clear_en  = pop_opp;
            clear_pos = opp_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= CELL_EMPTY;
            end
            turn_q <= (FIRST != 0) ? PL_X : PL_O;
            acc_q  <= 1'b0;
            rej_q  <= 1'b0;
        end else begin
            acc_q <= legal;
            rej_q <= mv_valid && !legal;
            if (take) begin
                // The vanishing cell is occupied, so it never equals mv_pos.
                if (clear_en) begin
                    cells[clear_pos] <= CELL_EMPTY;
                end
                cells[mv_pos] <= player_code(turn_q);
                turn_q        <= ~turn_q;
            end
        end
    end

    piece_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo_o (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_o),
        .pop   (pop_o),
        .din   (mv_pos),
        .head  (head_o),
        .count (cnt_o),
        .full  (full_o),
        .empty (empty_o)
    );

    piece_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo_x (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_x),
        .pop   (pop_x),
        .din   (mv_pos),
        .head  (head_x),
        .count (cnt_x),
        .full  (full_x),
        .empty (empty_x)
    );

    always_comb begin
        board = '0;
        for (int i = 0; i < CELLS; i++) begin
            board[2*i +: 2] = cells[i];
        end
    end

    assign turn = turn_q;
    assign acc  = acc_q;
    assign rej  = rej_q;

`ifdef VANISH_PREVIEW_EN
    assign vanish_o     = head_o;
    assign vanish_x     = head_x;
    assign vanish_o_vld = (VANISH_OWN != 0) ? full_o : (full_o && full_x);
    assign vanish_x_vld = (VANISH_OWN != 0) ? full_x : (full_o && full_x);
`endif

endmodule

// File: tb/tb_vanish_board_recorder.sv
// tb/tb_vanish_board_recorder.sv - directed self-checking bench for vanish_board_recorder
module tb_vanish_board_recorder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       mv_player;
    logic [3:0] mv_pos;
    logic       v_own, v_opp, v_big;

    logic [17:0] b_own, b_opp;
    logic [31:0] b_big;
    logic        t_own, t_opp, t_big;
    logic        a_own, a_opp, a_big;
    logic        r_own, r_opp, r_big;
    logic [1:0]  co_own, cx_own, co_opp, cx_opp;
    logic [2:0]  co_big, cx_big;
`ifdef VANISH_PREVIEW_EN
    logic [3:0]  vo_own, vx_own, vo_opp, vx_opp, vo_big, vx_big;
    logic        vov_own, vxv_own, vov_opp, vxv_opp, vov_big, vxv_big;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vanish_board_recorder #(.CELLS(9), .DEPTH(3), .VANISH_OWN(1), .FIRST(0)) u_own (
        .clk(clk), .rst(rst), .clr(clr), .mv_valid(v_own), .mv_player(mv_player), .mv_pos(mv_pos),
        .board(b_own), .turn(t_own), .acc(a_own), .rej(r_own), .cnt_o(co_own),
`ifdef VANISH_PREVIEW_EN
        .cnt_x(cx_own), .vanish_o(vo_own), .vanish_x(vx_own), .vanish_o_vld(vov_own), .vanish_x_vld(vxv_own)
`else
        .cnt_x(cx_own)
`endif
    );

    vanish_board_recorder #(.CELLS(9), .DEPTH(3), .VANISH_OWN(0), .FIRST(0)) u_opp (
        .clk(clk), .rst(rst), .clr(clr), .mv_valid(v_opp), .mv_player(mv_player), .mv_pos(mv_pos),
        .board(b_opp), .turn(t_opp), .acc(a_opp), .rej(r_opp), .cnt_o(co_opp),
`ifdef VANISH_PREVIEW_EN
        .cnt_x(cx_opp), .vanish_o(vo_opp), .vanish_x(vx_opp), .vanish_o_vld(vov_opp), .vanish_x_vld(vxv_opp)
`else
        .cnt_x(cx_opp)
`endif
    );

    vanish_board_recorder #(.CELLS(16), .DEPTH(5), .VANISH_OWN(1), .FIRST(0)) u_big (
        .clk(clk), .rst(rst), .clr(clr), .mv_valid(v_big), .mv_player(mv_player), .mv_pos(mv_pos),
        .board(b_big), .turn(t_big), .acc(a_big), .rej(r_big), .cnt_o(co_big),
`ifdef VANISH_PREVIEW_EN
        .cnt_x(cx_big), .vanish_o(vo_big), .vanish_x(vx_big), .vanish_o_vld(vov_big), .vanish_x_vld(vxv_big)
`else
        .cnt_x(cx_big)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d: 0 = own-vanish DUT, 1 = opponent-vanish DUT, 2 = 16-cell DUT
    task automatic move(input int d, input logic p, input logic [3:0] pos);
        mv_player = p;
        mv_pos    = pos;
        v_own     = (d == 0);
        v_opp     = (d == 1);
        v_big     = (d == 2);
        @(posedge clk);
        #1;
        v_own = 1'b0;
        v_opp = 1'b0;
        v_big = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; mv_player = 1'b0; mv_pos = '0;
        v_own = 1'b0; v_opp = 1'b0; v_big = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_board", 64'(b_own), 64'h0);
        check("rst_turn",  64'(t_own), 64'h0);
        check("rst_acc",   64'(a_own), 64'h0);
        check("rst_rej",   64'(r_own), 64'h0);
        check("rst_cnt_o", 64'(co_own), 64'h0);
        check("rst_cnt_x", 64'(cx_own), 64'h0);

        // wrong player first
        move(0, 1'b1, 4'd4);
        check("wrong_pl_rej",   64'(r_own), 64'h1);
        check("wrong_pl_acc",   64'(a_own), 64'h0);
        check("wrong_pl_board", 64'(b_own), 64'h0);
        check("wrong_pl_turn",  64'(t_own), 64'h0);

        // occupied cell
        move(0, 1'b0, 4'd4);
        check("o4_acc", 64'(a_own), 64'h1);
        move(0, 1'b1, 4'd0);
        check("x0_acc", 64'(a_own), 64'h1);
        move(0, 1'b0, 4'd4);
        check("occ_rej",   64'(r_own), 64'h1);
        check("occ_acc",   64'(a_own), 64'h0);
        check("occ_board", 64'(b_own), 64'h102);
        check("occ_turn",  64'(t_own), 64'h0);

        // clear together with a legal move
        clr = 1'b1;
        move(0, 1'b0, 4'd5);
        clr = 1'b0;
        check("clr_acc",   64'(a_own), 64'h0);
        check("clr_rej",   64'(r_own), 64'h0);
        check("clr_board", 64'(b_own), 64'h0);
        check("clr_turn",  64'(t_own), 64'h0);
        check("clr_cnt_o", 64'(co_own), 64'h0);

        // own-vanish: O0 X3 O1 X4 O2 X5 O6
        move(0, 1'b0, 4'd0); move(0, 1'b1, 4'd3);
        move(0, 1'b0, 4'd1); move(0, 1'b1, 4'd4);
        move(0, 1'b0, 4'd2); move(0, 1'b1, 4'd5);
        check("own_full_board", 64'(b_own), 64'hA95);
        check("own_full_cnt_o", 64'(co_own), 64'h3);
`ifdef VANISH_PREVIEW_EN
        check("own_prev_o_pre", 64'(vo_own), 64'h0);
        check("own_prev_vld",   64'(vov_own), 64'h1);
`endif
        move(0, 1'b0, 4'd6);
        check("own_o6_acc",   64'(a_own), 64'h1);
        check("own_o6_board", 64'(b_own), 64'h1A94);
        check("own_o6_cnt_o", 64'(co_own), 64'h3);
        check("own_o6_cnt_x", 64'(cx_own), 64'h3);
`ifdef VANISH_PREVIEW_EN
        check("own_prev_o_post", 64'(vo_own), 64'h1);
`endif
        move(0, 1'b1, 4'd7);
        check("own_x7_board", 64'(b_own), 64'h9A14);
        move(0, 1'b0, 4'd9);
        check("pos9_rej", 64'(r_own), 64'h1);
        move(0, 1'b0, 4'd15);
        check("pos15_rej",   64'(r_own), 64'h1);
        check("pos15_board", 64'(b_own), 64'h9A14);

        // opponent-vanish: O0 X3 O1 X4 O2 X5 O6 X7 O8
        move(1, 1'b0, 4'd0); move(1, 1'b1, 4'd3);
        move(1, 1'b0, 4'd1); move(1, 1'b1, 4'd4);
        move(1, 1'b0, 4'd2); move(1, 1'b1, 4'd5);
        move(1, 1'b0, 4'd6);
        check("opp_o6_board", 64'(b_opp), 64'h1A15);
        check("opp_o6_cnt_x", 64'(cx_opp), 64'h2);
        check("opp_o6_cnt_o", 64'(co_opp), 64'h3);
        move(1, 1'b1, 4'd7);
        check("opp_x7_board", 64'(b_opp), 64'h9A15);
        check("opp_x7_cnt_x", 64'(cx_opp), 64'h3);
        move(1, 1'b0, 4'd8);
        check("opp_o8_board", 64'(b_opp), 64'h19815);
        check("opp_o8_cnt_x", 64'(cx_opp), 64'h2);

        // 16 cells, depth 5: O0 X1 O2 ... X13, then O0 X1 to wrap again
        for (int k = 0; k < 14; k++) begin
            move(2, 1'(k % 2), 4'(k));
            check("big_acc", 64'(a_big), 64'h1);
            if (k == 10) begin
                check("big_o10_c0", 64'(b_big[1:0]), 64'h0);
                check("big_o10_c2", 64'(b_big[5:4]), 64'h1);
            end
            if (k == 11) begin
                check("big_x11_c1", 64'(b_big[3:2]), 64'h0);
            end
        end
        check("big_14_board", 64'(b_big), 64'h09999900);
        check("big_14_cnt_o", 64'(co_big), 64'h5);
        check("big_14_cnt_x", 64'(cx_big), 64'h5);
        move(2, 1'b1, 4'd14);
        check("big_wrong_pl", 64'(r_big), 64'h1);
        move(2, 1'b0, 4'd0);
        move(2, 1'b1, 4'd1);
        check("big_wrap_board", 64'(b_big), 64'h09999009);

        // mid-game reset
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_board", 64'(b_own), 64'h0);
        check("mid_rst_cnt_o", 64'(co_own), 64'h0);
        check("mid_rst_turn",  64'(t_own), 64'h0);
        check("mid_rst_big",   64'(b_big), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vanish_board_recorder.md
# vanish_board_recorder

Parametrised board-state recorder for the "vanishing pieces" tic-tac-toe variant. It holds the grid, enforces turn order and cell occupancy, and keeps a per-player FIFO of placed cells so each player has at most DEPTH pieces on the board. Grid size, history depth and vanish mode are configurable. It sits between the input/validation front end and the win checker / display, and is the single owner of board state.

## Interface
- CELLS, 9 — number of grid cells; valid positions are 0..CELLS-1.
- DEPTH, 3 — maximum number of pieces per player on the board.
- VANISH_OWN, 1 — 1: the mover's own oldest piece vanishes; 0: the opponent's oldest piece vanishes.
- FIRST, 0 — player to move after reset/clear; 0 = O, 1 = X.
- PW, $clog2(CELLS) — position width (derived).
- clk  in  1  — system clock.
- rst  in  1  — synchronous, active-low reset.
- clr  in  1  — synchronous new-game clear; same effect as reset.
- mv_valid  in  1  — move request strobe, one cycle.
- mv_player  in  1  — 1 = X, 0 = O.
- mv_pos  in  PW  — target cell.
- board  out  2*CELLS  — cell i at [2i+1:2i]; 00 = empty, 01 = O, 10 = X.
- turn  out  1  — player expected next.
- acc  out  1  — one-cycle pulse: move accepted.
- rej  out  1  — one-cycle pulse: move rejected.
- cnt_o, cnt_x  out  $clog2(DEPTH+1) each  — pieces currently on the board per player.
- vanish_o, vanish_x  out  PW each  — oldest cell per player (VANISH_PREVIEW_EN only).
- vanish_o_vld, vanish_x_vld  out  1 each  — that player's oldest piece vanishes on the next qualifying move (VANISH_PREVIEW_EN only).

## Operation
- Reset / clear: board all 00, turn = FIRST, acc = rej = 0, both counts 0, FIFOs empty, preview outputs 0.
- A move is legal when all hold: mv_player == turn, mv_pos < CELLS, and the cell is 00 in the current board. A cell that would vanish on this same move is not considered free.
- Illegal move: rej = 1; no state change.
- Legal move:
  - Write the mover's code into the cell and push mv_pos into the mover's FIFO.
  - Toggle turn; pulse acc.
- Vanish, VANISH_OWN = 1: if the mover's count == DEPTH before the move, pop the mover's oldest cell and write 00 to it. The mover's count stays at DEPTH.
- Vanish, VANISH_OWN = 0: if the opponent's count == DEPTH and the mover's count == DEPTH before the move, pop the opponent's oldest cell and clear it. The opponent's count decrements; the mover's count saturates at DEPTH.
- FIFO pointers wrap modulo DEPTH. DEPTH need not be a power of two; the pointer wraps explicitly at DEPTH-1.
- vanish_*_vld follows the rule of the active mode: under VANISH_OWN = 1 it is high when that player's count == DEPTH; under VANISH_OWN = 0 it is high when both counts == DEPTH.

## Timing
- Fully registered. Board, turn, counts and acc/rej update on the clk edge that samples mv_valid = 1, and are visible the following cycle.
- Latency is one cycle. A new move is accepted every cycle, and back-to-back moves see the updated board.
- Priority: rst > clr > mv_valid. A move in the same cycle as clr is dropped, and neither acc nor rej pulses.
- A reset asserted mid-game discards all history immediately.
- acc and rej are mutually exclusive and are 0 when mv_valid = 0.

## Configuration
- VANISH_PREVIEW_EN defined: vanish_o, vanish_x, vanish_o_vld and vanish_x_vld are present and driven from the FIFO heads; the display uses them to blink the piece about to vanish.
- VANISH_PREVIEW_EN undefined: those four ports are absent. Game behaviour is otherwise identical.

## Structure
- Shared package vanish_pkg holds:
  - cell codes CELL_EMPTY = 2'b00, CELL_O = 2'b01, CELL_X = 2'b10;
  - player constants PL_O = 0, PL_X = 1;
  - a function mapping player to cell code.
- Sub-module piece_fifo (parameters DEPTH, PW) provides push, pop, head, count, full and empty. It is instantiated once per player; the top handles legality, board writes and turn.

## Test plan
- Reset, then X tries cell 4 with FIRST = 0 -> rej = 1, board unchanged, turn = 0.
- O4, X0, then O4 again -> third move rej = 1; board[9:8] = 01, board[1:0] = 10.
- VANISH_OWN = 1, DEPTH = 3: O0 X3 O1 X4 O2 X5 O6 -> on O6, cell 0 becomes 00 and cell 6 becomes 01; cnt_o = 3; vanish_o advances from 0 to 1.
- VANISH_OWN = 0, DEPTH = 3: O0 X3 O1 X4 O2 X5, then O6 -> cell 3 cleared, cnt_x = 2. Then X7 -> cell 0 not cleared, because cnt_o = 3 but cnt_x was 2.
- clr asserted together with a legal mv_valid -> neither acc nor rej; board all 00; turn = FIRST.
- CELLS = 16, DEPTH = 5: play 14 alternating legal moves -> FIFO wrap is correct, every vanished cell equals the oldest push, mv_pos = 16+ is rejected.
